// File: rtl/pulse_cmd_parser.sv
// Byte-level command decoder: assembles framed parameter writes from UART bytes
// and holds the pulse parameter registers that drive the pulses generator.
`timescale 1ns/1ps
module pulse_cmd_parser #(
  parameter int unsigned TIMEOUT = 120000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [7:0]  period,
  output logic [15:0] p1width,
  output logic [15:0] delay,
  output logic [15:0] p2width,
  output logic [31:0] nut_del,
  output logic [31:0] nut_wid,
  output logic        pump,
  output logic        block,
  output logic [7:0]  pulse_block,
  output logic [15:0] pulse_block_off,
  output logic [7:0]  cpmg,
  output logic        rx_done,
  output logic        cmd_err,
  output logic        busy
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LEN_W = 3;

  localparam logic [7:0]  DEF_PERIOD    = 8'd1;
  localparam logic [15:0] DEF_P1WIDTH   = 16'd30;
  localparam logic [15:0] DEF_DELAY     = 16'd200;
  localparam logic [15:0] DEF_P2WIDTH   = 16'd60;
  localparam logic [31:0] DEF_NUT_DEL   = 32'd300;
  localparam logic [31:0] DEF_NUT_WID   = 32'd300;
  localparam logic        DEF_PUMP      = 1'b1;
  localparam logic        DEF_BLOCK     = 1'b1;
  localparam logic [7:0]  DEF_PB        = 8'd50;
  localparam logic [15:0] DEF_PB_OFF    = 16'd100;
  localparam logic [7:0]  DEF_CPMG      = 8'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       cmd_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      shift_q;
  logic [CNT_W-1:0] idle_q;

  logic [LEN_W-1:0] len_c;
  logic             known_c;
  logic             decode_c;

  // Payload length of the incoming byte when read as a command code.
  always_comb begin
    len_c   = '0;
    known_c = 1'b1;
    case (rx_byte)
      8'h00:                             len_c = LEN_W'(0);
      8'h01, 8'h07, 8'h08, 8'h09, 8'h0B: len_c = LEN_W'(1);
      8'h02, 8'h03, 8'h04, 8'h0A:        len_c = LEN_W'(2);
      8'h05, 8'h06:                      len_c = LEN_W'(4);
      default:                           known_c = 1'b0;
    endcase
  end

  // A byte is a command byte in IDLE and also in COMMIT, so back-to-back packets lose nothing.
  assign decode_c = rx_valid && ((state_q == ST_IDLE) || (state_q == ST_COMMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      cmd_q           <= '0;
      cnt_q           <= '0;
      shift_q         <= '0;
      idle_q          <= '0;
      period          <= DEF_PERIOD;
      p1width         <= DEF_P1WIDTH;
      delay           <= DEF_DELAY;
      p2width         <= DEF_P2WIDTH;
      nut_del         <= DEF_NUT_DEL;
      nut_wid         <= DEF_NUT_WID;
      pump            <= DEF_PUMP;
      block           <= DEF_BLOCK;
      pulse_block     <= DEF_PB;
      pulse_block_off <= DEF_PB_OFF;
      cpmg            <= DEF_CPMG;
      rx_done         <= 1'b0;
      cmd_err         <= 1'b0;
      busy            <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      cmd_err <= 1'b0;

      case (state_q)
        ST_IDLE: ;
        ST_DATA: begin
          // A full idle window has elapsed: the abort wins over any byte on this edge.
          if (idle_q == CNT_W'(TIMEOUT)) begin
            cmd_err <= 1'b1;
            state_q <= ST_IDLE;
            busy    <= 1'b0;
          end else if (rx_valid) begin
            shift_q <= {shift_q[23:0], rx_byte};
            cnt_q   <= cnt_q - LEN_W'(1);
            idle_q  <= '0;
            if (cnt_q == LEN_W'(1)) begin
              state_q <= ST_COMMIT;
            end
          end else begin
            idle_q <= idle_q + CNT_W'(1);
          end
        end
        ST_COMMIT: begin
          case (cmd_q)
            8'h00: begin
              period          <= DEF_PERIOD;
              p1width         <= DEF_P1WIDTH;
              delay           <= DEF_DELAY;
              p2width         <= DEF_P2WIDTH;
              nut_del         <= DEF_NUT_DEL;
              nut_wid         <= DEF_NUT_WID;
              pump            <= DEF_PUMP;
              block           <= DEF_BLOCK;
              pulse_block     <= DEF_PB;
              pulse_block_off <= DEF_PB_OFF;
              cpmg            <= DEF_CPMG;
            end
            8'h01:   period          <= shift_q[7:0];
            8'h02:   p1width         <= shift_q[15:0];
            8'h03:   delay           <= shift_q[15:0];
            8'h04:   p2width         <= shift_q[15:0];
            8'h05:   nut_del         <= shift_q;
            8'h06:   nut_wid         <= shift_q;
            8'h07:   pump            <= shift_q[0];
            8'h08:   block           <= shift_q[0];
            8'h09:   pulse_block     <= shift_q[7:0];
            8'h0A:   pulse_block_off <= shift_q[15:0];
            8'h0B:   cpmg            <= shift_q[7:0];
            default: ;
          endcase
          rx_done <= 1'b1;
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase

      if (decode_c) begin
        if (!known_c) begin
          cmd_err <= 1'b1;
        end else if (len_c == LEN_W'(0)) begin
          cmd_q   <= rx_byte;
          state_q <= ST_COMMIT;
          busy    <= 1'b1;
        end else begin
          cmd_q   <= rx_byte;
          cnt_q   <= len_c;
          shift_q <= '0;
          idle_q  <= '0;
          state_q <= ST_DATA;
          busy    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_cmd_parser.sv
// Bench for pulse_cmd_parser: directed literal checks plus a random byte stream
// compared every cycle against a packet-level timestamp model.
`timescale 1ns/1ps
module tb_pulse_cmd_parser;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic [7:0]  period;
  logic [15:0] p1width;
  logic [15:0] delay;
  logic [15:0] p2width;
  logic [31:0] nut_del;
  logic [31:0] nut_wid;
  logic        pump;
  logic        block;
  logic [7:0]  pulse_block;
  logic [15:0] pulse_block_off;
  logic [7:0]  cpmg;
  logic        rx_done;
  logic        cmd_err;
  logic        busy;

  pulse_cmd_parser #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .period(period), .p1width(p1width), .delay(delay), .p2width(p2width),
    .nut_del(nut_del), .nut_wid(nut_wid), .pump(pump), .block(block),
    .pulse_block(pulse_block), .pulse_block_off(pulse_block_off), .cpmg(cpmg),
    .rx_done(rx_done), .cmd_err(cmd_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  longint edge_n  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endfunction

  // Reference model state: expected register file plus packet bookkeeping by edge timestamps.
  logic [7:0]  m_period, m_pb, m_cpmg;
  logic [15:0] m_p1, m_delay, m_p2, m_pbo;
  logic [31:0] m_nd, m_nw;
  logic        m_pump, m_block, m_done, m_err, m_busy;

  bit          in_pkt;
  int          need;
  logic [31:0] acc;
  logic [7:0]  pkt_cmd;
  longint      last_edge;
  bit          commit_pend;
  longint      commit_edge;
  logic [7:0]  commit_cmd;
  logic [31:0] commit_val;
  int          len_l;

  function automatic int code_len(input logic [7:0] c);
    case (c)
      8'h00: return 0;
      8'h01, 8'h07, 8'h08, 8'h09, 8'h0B: return 1;
      8'h02, 8'h03, 8'h04, 8'h0A: return 2;
      8'h05, 8'h06: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic void m_defaults();
    m_period = 8'd1;   m_p1 = 16'd30;  m_delay = 16'd200; m_p2 = 16'd60;
    m_nd = 32'd300;    m_nw = 32'd300; m_pump = 1'b1;     m_block = 1'b1;
    m_pb = 8'd50;      m_pbo = 16'd100; m_cpmg = 8'd4;
  endfunction

  function automatic void m_apply(input logic [7:0] c, input logic [31:0] v);
    case (c)
      8'h00: m_defaults();
      8'h01: m_period = v[7:0];
      8'h02: m_p1 = v[15:0];
      8'h03: m_delay = v[15:0];
      8'h04: m_p2 = v[15:0];
      8'h05: m_nd = v;
      8'h06: m_nw = v;
      8'h07: m_pump = v[0];
      8'h08: m_block = v[0];
      8'h09: m_pb = v[7:0];
      8'h0A: m_pbo = v[15:0];
      8'h0B: m_cpmg = v[7:0];
      default: ;
    endcase
  endfunction

  function automatic void schedule(input logic [7:0] c, input logic [31:0] v);
    commit_pend = 1'b1;
    commit_edge = edge_n + 1;
    commit_cmd  = c;
    commit_val  = v;
  endfunction

  initial begin
    m_defaults();
    in_pkt = 1'b0; commit_pend = 1'b0; need = 0; acc = '0;
    pkt_cmd = '0; last_edge = 0; commit_edge = 0; commit_cmd = '0; commit_val = '0;
    m_done = 1'b0; m_err = 1'b0; m_busy = 1'b0;
  end

  // Advance the model at each edge, then compare every output shortly after it.
  always @(posedge clk) begin
    edge_n++;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (reset) begin
      m_defaults();
      in_pkt = 1'b0;
      commit_pend = 1'b0;
    end else begin
      if (commit_pend && commit_edge == edge_n) begin
        m_apply(commit_cmd, commit_val);
        m_done = 1'b1;
        commit_pend = 1'b0;
      end
      if (in_pkt && edge_n == last_edge + longint'(TO) + 1) begin
        in_pkt = 1'b0;
        m_err  = 1'b1;
      end else if (rx_valid) begin
        if (in_pkt) begin
          acc = (acc << 8) | 32'(rx_byte);
          need--;
          last_edge = edge_n;
          if (need == 0) begin
            in_pkt = 1'b0;
            schedule(pkt_cmd, acc);
          end
        end else begin
          len_l = code_len(rx_byte);
          if (len_l < 0) m_err = 1'b1;
          else if (len_l == 0) schedule(8'h00, 32'd0);
          else begin
            in_pkt = 1'b1; need = len_l; acc = '0;
            pkt_cmd = rx_byte; last_edge = edge_n;
          end
        end
      end
    end
    m_busy = in_pkt || commit_pend;
    #1;
    chk("period", 32'(period), 32'(m_period));
    chk("p1width", 32'(p1width), 32'(m_p1));
    chk("delay", 32'(delay), 32'(m_delay));
    chk("p2width", 32'(p2width), 32'(m_p2));
    chk("nut_del", nut_del, m_nd);
    chk("nut_wid", nut_wid, m_nw);
    chk("pump", 32'(pump), 32'(m_pump));
    chk("block", 32'(block), 32'(m_block));
    chk("pulse_block", 32'(pulse_block), 32'(m_pb));
    chk("pulse_block_off", 32'(pulse_block_off), 32'(m_pbo));
    chk("cpmg", 32'(cpmg), 32'(m_cpmg));
    chk("rx_done", 32'(rx_done), 32'(m_done));
    chk("cmd_err", 32'(cmd_err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_busy));
  end

  // Entered and left at a falling edge; the byte is sampled on the rising edge in between.
  task automatic send(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 60) return 0;
    if (r < 85) return int'($urandom_range(1, 3));
    return int'($urandom_range(TO - 1, TO + 2));
  endfunction

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("lit_rst_period", 32'(period), 32'd1);
    chk("lit_rst_nut_wid", nut_wid, 32'd300);
    chk("lit_rst_pb_off", 32'(pulse_block_off), 32'd100);
    chk("lit_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    send(8'h02, 0); send(8'h01, 0); send(8'h2C, 0);
    chk("lit_p1_commit_busy", 32'(busy), 32'd1);
    chk("lit_p1_not_yet", 32'(p1width), 32'd30);
    @(negedge clk);
    chk("lit_p1width", 32'(p1width), 32'd300);
    chk("lit_p1_done", 32'(rx_done), 32'd1);
    @(negedge clk);
    chk("lit_p1_done_low", 32'(rx_done), 32'd0);

    send(8'h05, 0); send(8'h00, 0); send(8'h01, 0); send(8'h86, 0); send(8'hA0, 0);
    @(negedge clk);
    chk("lit_nut_del", nut_del, 32'd100000);
    send(8'h07, 0); send(8'hFE, 0);
    @(negedge clk);
    chk("lit_pump_bit0", 32'(pump), 32'd0);

    send(8'h03, 0); send(8'h12, TO);
    chk("lit_to_not_yet", 32'(cmd_err), 32'd0);
    @(negedge clk);
    chk("lit_to_err", 32'(cmd_err), 32'd1);
    chk("lit_to_busy", 32'(busy), 32'd0);
    chk("lit_to_delay", 32'(delay), 32'd200);
    send(8'h03, 0); send(8'h00, 0); send(8'h64, 0);
    @(negedge clk);
    chk("lit_delay100", 32'(delay), 32'd100);

    send(8'h3F, 0);
    chk("lit_bad_err", 32'(cmd_err), 32'd1);
    chk("lit_bad_nodone", 32'(rx_done), 32'd0);
    send(8'h01, 0); send(8'h05, 0); send(8'h0B, 0);
    chk("lit_period5", 32'(period), 32'd5);
    chk("lit_period_done", 32'(rx_done), 32'd1);
    send(8'h08, 0);
    @(negedge clk);
    chk("lit_cpmg8", 32'(cpmg), 32'd8);
    chk("lit_cpmg_done", 32'(rx_done), 32'd1);

    send(8'h04, 0); send(8'hAA, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("lit_partial_p2", 32'(p2width), 32'd60);
    chk("lit_partial_busy", 32'(busy), 32'd0);
    send(8'h02, 0); send(8'h01, 0); send(8'hF4, 0);
    @(negedge clk);
    chk("lit_p1_500", 32'(p1width), 32'd500);
    send(8'h00, 0);
    chk("lit_restore_wait", 32'(p1width), 32'd500);
    @(negedge clk);
    chk("lit_restore_p1", 32'(p1width), 32'd30);
    chk("lit_restore_done", 32'(rx_done), 32'd1);
    @(negedge clk);
    chk("lit_restore_done_low", 32'(rx_done), 32'd0);

    for (int p = 0; p < 250; p++) begin
      logic [7:0] c;
      int r, nb;
      r = int'($urandom_range(0, 15));
      if (r < 13) c = 8'(r);
      else c = 8'($urandom_range(13, 255));
      nb = code_len(c);
      if (nb < 0) nb = 0;
      if (nb > 0 && $urandom_range(0, 9) == 0) nb = int'($urandom_range(0, nb - 1));
      send(c, pick_gap());
      for (int i = 0; i < nb; i++) send(8'($urandom), pick_gap());
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    end
    repeat (TO + 5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
